uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the team's UART transmitter. Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 parity bit, 1 stop bit (1). Asynchronous serial input is synchronised, start bits are validated, and each bit is sampled at mid-period. Each received byte is presented on a valid/ack holding register with parity, framing and overrun status.

---
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (start, DATA_BITS data LSB first, parity, stop) with valid/ack holding register.
// Define UART_RX_BREAK_DETECT_EN to report all-zero frames on break_det instead of delivering them.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d, stop_q, stop_d, done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 bit_end, brk_frame, deliver;
    assign bit_end = cnt_q == CW'(CLKS_PER_BIT-1);
`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q;
    assign brk_frame = shreg_q == '0 && !par_q && !stop_q;
    assign break_det = brk_q;
`else
    assign brk_frame = 1'b0;
    assign break_det = 1'b0;
`endif
    assign deliver = done_q && !brk_frame;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_s_q ? IDLE : START;
            end
            START: if (cnt_q == CW'(CLKS_PER_BIT/2-1)) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                cnt_d          = '0;
                shreg_d[idx_q] = rx_s_q;
                idx_d          = idx_q + IW'(1);
                state_d        = idx_q == IW'(DATA_BITS-1) ? PARITY : DATA;
            end
            PARITY: if (bit_end) begin
                cnt_d   = '0;
                par_d   = rx_s_q;
                state_d = STOP;
            end
            STOP: if (bit_end) begin
                cnt_d   = '0;
                stop_d  = rx_s_q;
                done_d  = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                state_d = (shreg_q == '0 && !par_q && !rx_s_q) ? BRK_WAIT : IDLE;
`else
                state_d = IDLE;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            BRK_WAIT: begin
                cnt_d   = '0;
                state_d = rx_s_q ? IDLE : BRK_WAIT;
            end
`endif
            default: state_d = IDLE;
        endcase
        data_d  = deliver ? shreg_q : data_q;
        perr_d  = deliver ? (par_q != ((^shreg_q) ^ 1'(PARITY_ODD))) : perr_q;
        ferr_d  = deliver ? !stop_q : ferr_q;
        valid_d = deliver ? 1'b1 : (rd_ack ? 1'b0 : valid_q);
        // an ack landing with a new delivery consumes the old byte, so no overrun
        ovr_d   = (valid_q && rd_ack) ? 1'b0 : ((deliver && valid_q) ? 1'b1 : ovr_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end
`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) brk_q <= 1'b0;
        else     brk_q <= done_q && brk_frame;
    end
`endif
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; an odd-parity instance shares the line for the parity check.
module tb_uart_rx;
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_ack = 1'b0;
    logic [7:0] data_out, data_out_o;
    logic data_valid, parity_err, frame_err, overrun, break_det;
    logic data_valid_o, parity_err_o, frame_err_o, overrun_o, break_det_o;
    int n_cmp = 0, n_err = 0, brk_cnt = 0;
    always #5 clk = ~clk;
    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack), .data_out(data_out),
        .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .break_det(break_det));
    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack), .data_out(data_out_o),
        .data_valid(data_valid_o), .parity_err(parity_err_o), .frame_err(frame_err_o),
        .overrun(overrun_o), .break_det(break_det_o));
    always @(posedge clk) if (break_det) brk_cnt <= brk_cnt + 1;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // drives n clocks of a frame; delivery lands on the 172nd edge after the start bit
    task automatic send(input logic [7:0] d, input logic p, input logic s, input bit ack_dlv, input int n);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            rx = bits[i/16];
            rd_ack = ack_dlv && i == 171;
            step();
        end
        rx = 1'b1;
        rd_ack = 1'b0;
    endtask
    task automatic ack();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
    endtask
    initial begin
        repeat (3) step();
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_brk", break_det, 1'b0);
        rst = 1'b0;
        repeat (3) step();
        send(8'hA5, 1'b0, 1'b1, 1'b0, 171);
        chk("a5_not_yet", data_valid, 1'b0);
        step();
        chk("a5_valid", data_valid, 1'b1);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_perr", parity_err, 1'b0);
        chk("a5_ferr", frame_err, 1'b0);
        repeat (4) step();
        ack();
        chk("a5_ack", data_valid, 1'b0);
        send(8'h3C, 1'b1, 1'b1, 1'b0, 176);
        chk("3c_data", data_out, 8'h3C);
        chk("3c_perr_even", parity_err, 1'b1);
        chk("3c_perr_odd", parity_err_o, 1'b0);
        ack();
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (20) step();
        chk("glitch_valid", data_valid, 1'b0);
        send(8'h55, 1'b0, 1'b0, 1'b0, 176);
        chk("55_data", data_out, 8'h55);
        chk("55_ferr", frame_err, 1'b1);
        chk("55_perr", parity_err, 1'b0);
        ack();
        send(8'h11, 1'b0, 1'b1, 1'b0, 176);
        send(8'h22, 1'b0, 1'b1, 1'b0, 176);
        chk("ovr_data", data_out, 8'h22);
        chk("ovr_set", overrun, 1'b1);
        ack();
        chk("ovr_clr", overrun, 1'b0);
        chk("ovr_valid_clr", data_valid, 1'b0);
        send(8'h11, 1'b0, 1'b1, 1'b0, 176);
        send(8'h22, 1'b0, 1'b1, 1'b1, 176);
        chk("ackdlv_ovr", overrun, 1'b0);
        chk("ackdlv_valid", data_valid, 1'b1);
        chk("ackdlv_data", data_out, 8'h22);
        send(8'hF0, 1'b0, 1'b1, 1'b0, 88);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_valid", data_valid, 1'b0);
        chk("mid_rst_perr", parity_err, 1'b0);
        chk("mid_rst_ferr", frame_err, 1'b0);
        chk("mid_rst_ovr", overrun, 1'b0);
        chk("mid_rst_brk", break_det, 1'b0);
        step();
        rst = 1'b0;
        repeat (3) step();
        send(8'h0F, 1'b0, 1'b1, 1'b0, 176);
        chk("0f_data", data_out, 8'h0F);
        chk("0f_valid", data_valid, 1'b1);
        chk("0f_ferr", frame_err, 1'b0);
        chk("0f_perr", parity_err, 1'b0);
        ack();
        rx = 1'b0;
        repeat (174) step();
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_no_valid", data_valid, 1'b0);
        repeat (18) step();
        rx = 1'b1;
        repeat (250) step();
        chk("brk_pulses", 8'(brk_cnt), 8'd1);
        chk("brk_valid", data_valid, 1'b0);
`else
        chk("low_data", data_out, 8'h00);
        chk("low_ferr", frame_err, 1'b1);
        chk("low_valid", data_valid, 1'b1);
        repeat (18) step();
        rx = 1'b1;
        repeat (250) step();
        chk("low_brk", break_det, 1'b0);
        ack();
        chk("low_ack_valid", data_valid, 1'b0);
`endif
        send(8'h81, 1'b0, 1'b1, 1'b0, 176);
        chk("81_data", data_out, 8'h81);
        chk("81_valid", data_valid, 1'b1);
        chk("81_ferr", frame_err, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
